// File: rtl/aud_i2s_tx.sv
// I2S DAC serialiser: latches one DSP sample per LRCK frame and shifts it MSB-first
// onto the codec data pin in the BCLK domain, with LRCK sampled as data.
module aud_i2s_tx #(
  parameter int DATA_W    = 16,
  parameter int I2S_DELAY = 1,
  parameter bit STEREO    = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_aud_dacdat,
  output logic              o_busy,
  output logic              o_frame_start,
  output logic              o_slot_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int DLY_W = (I2S_DELAY > 1) ? $clog2(I2S_DELAY) : 1;

  typedef enum logic [1:0] {S_SYNC, S_DELAY, S_SEND, S_HOLD} state_e;

  localparam state_e START_STATE = (I2S_DELAY == 1) ? S_SEND : S_DELAY;

  state_e            state_q, state_d;
  logic              lrck_q;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              frame_start_q, frame_start_d;
  logic              slot_err_q, slot_err_d;

  logic lrck_edge, fall_edge, rise_edge, busy;

  assign lrck_edge = i_daclrck ^ lrck_q;
  assign fall_edge = lrck_edge & lrck_q;
  assign rise_edge = lrck_edge & ~lrck_q;
  assign busy      = (state_q == S_DELAY) || (state_q == S_SEND);

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    dly_d         = dly_q;
    frame_start_d = 1'b0;
    slot_err_d    = lrck_edge & busy;

    case (state_q)
      S_DELAY: begin
        if (int'(dly_q) == I2S_DELAY - 2) state_d = S_SEND;
        else                              dly_d   = dly_q + DLY_W'(1);
      end
      S_SEND: begin
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (int'(cnt_q) == DATA_W - 1) state_d = S_HOLD;
      end
      default: ;
    endcase

    // Slot edges override whatever the current slot was doing.
    if (fall_edge && i_en) begin
      sample_d      = i_dac_data;
      shift_d       = i_dac_data;
      frame_start_d = 1'b1;
      cnt_d         = '0;
      dly_d         = '0;
      state_d       = START_STATE;
    end else if (rise_edge && (state_q != S_SYNC)) begin
      cnt_d = '0;
      dly_d = '0;
      if (STEREO) begin
        shift_d = sample_q;
        state_d = START_STATE;
      end else begin
        // Mono: the right slot is pure silence, so it is not shifted at all.
        shift_d = '0;
        state_d = S_HOLD;
      end
    end else if (fall_edge) begin
      state_d = S_SYNC;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_SYNC;
      lrck_q        <= 1'b0;
      sample_q      <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      dly_q         <= '0;
      frame_start_q <= 1'b0;
      slot_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lrck_q        <= i_daclrck;
      sample_q      <= sample_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      dly_q         <= dly_d;
      frame_start_q <= frame_start_d;
      slot_err_q    <= slot_err_d;
    end
  end

  // The edge cycle already belongs to the new slot, so a truncated slot is silenced there.
  assign o_aud_dacdat  = (state_q == S_SEND) && !lrck_edge && shift_q[DATA_W-1];
  assign o_busy        = busy;
  assign o_frame_start = frame_start_q;
  assign o_slot_err    = slot_err_q;

endmodule
